// File: rtl/rv32m_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_muldiv
// Brief    : Iterative RV32M multiply/divide unit (shift-add / restoring).
//            Divider built only when RV32M_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rv32m_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef RV32M_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_last_iter = 5'd31;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [1:0]        r_f3;
    logic              r_neg;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    // Operand signedness: MULH both, MULHSU only A, DIV/REM both.
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;

    assign w_a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign w_b_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn & rs1_val[XLEN-1];
    assign w_b_neg = w_b_sgn & rs2_val[XLEN-1];
    assign w_a_mag = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag = w_b_neg ? -rs2_val : rs2_val;
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    assign w_neg   = (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Multiplier: {r_hi, r_lo} is the product accumulator, r_lo starts as |B|.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_mul_fix;
    logic [XLEN-1:0]   w_mul_res;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_lo[XLEN-1:1]};
    assign w_mul_fix  = r_neg ? -w_mul_next : w_mul_next;
    assign w_mul_res  = (r_f3 == 2'b00) ? w_mul_fix[XLEN-1:0] : w_mul_fix[2*XLEN-1:XLEN];

`ifdef RV32M_DIV_EN
    // Divider: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_res;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_fast_res;

    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_a};
    assign w_div_ge    = ~w_div_diff[XLEN];
    assign w_rem_next  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_quo_next  = {r_lo[XLEN-2:0], w_div_ge};
    assign w_div_raw   = r_f3[1] ? w_rem_next : w_quo_next;
    assign w_div_res   = r_neg ? -w_div_raw : w_div_raw;

    assign w_div0      = (rs2_val == {XLEN{1'b0}});
    assign w_ovf       = ~funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_val == {XLEN{1'b1}});
    assign w_fast_res  = w_div0 ? (funct3[1] ? rs1_val : {XLEN{1'b1}})
                                : (funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_f3    <= 2'b00;
            r_neg   <= 1'b0;
            r_a     <= {XLEN{1'b0}};
            r_hi    <= {XLEN{1'b0}};
            r_lo    <= {XLEN{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= {XLEN{1'b0}};
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f3  <= funct3[1:0];
                        r_neg <= w_neg;
                        r_hi  <= {XLEN{1'b0}};
                        r_cnt <= 5'd0;
                        busy  <= 1'b1;
                        if (!funct3[2]) begin
                            r_state <= S_MUL;
                            r_a     <= w_a_mag;
                            r_lo    <= w_b_mag;
                        end else begin
`ifdef RV32M_DIV_EN
                            if (w_div0 || w_ovf) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                                result  <= w_fast_res;
                            end else begin
                                r_state <= S_DIV;
                                r_a     <= w_b_mag;
                                r_lo    <= w_a_mag;
                            end
`else
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            result  <= {XLEN{1'b0}};
`endif
                        end
                    end
                end
                S_MUL: begin
                    {r_hi, r_lo} <= w_mul_next;
                    r_cnt        <= r_cnt + 5'd1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        result  <= w_mul_res;
                    end
                end
`ifdef RV32M_DIV_EN
                S_DIV: begin
                    r_hi  <= w_rem_next;
                    r_lo  <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        result  <= w_div_res;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32m_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32m_muldiv
// Brief    : Self-checking bench for rv32m_muldiv against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32m_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    rv32m_muldiv #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        int          ia = a;
        int          ib = b;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            default: begin
`ifdef RV32M_DIV_EN
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                case (f3)
                    3'b100:  return ia / ib;
                    3'b101:  return a / b;
                    3'b110:  return ia % ib;
                    default: return a % b;
                endcase
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 33;
`ifdef RV32M_DIV_EN
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Issues one op and waits for done; returns result, cycles to done (0 = timeout)
    // and whether busy stayed high from acceptance through done.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_all);
        @(posedge clk);
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
        lat = 0; busy_all = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (!busy) busy_all = 1'b0;
            if (done) begin lat = i; break; end
            @(posedge clk); #1;
        end
        res = result;
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b);
        logic [31:0] res;
        int          lat;
        bit          ball;
        logic [31:0] exp_res = ref_result(f3, a, b);
        int          exp_lat = ref_latency(f3, a, b);
        do_op(f3, a, b, res, lat, ball);
        n_checks++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s result f3=%b a=%h b=%h got=%h exp=%h", name, f3, a, b, res, exp_res);
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency f3=%b got=%0d exp=%0d", name, f3, lat, exp_lat);
        end
        n_checks++;
        if (!ball) begin
            n_fail++;
            $display("FAIL %s busy dropped before done got=0 exp=1", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done);
        end
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result got=%h exp=00000000", result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul_directed;
        check_op("mul_7x_m3", 3'b000, 32'd7, 32'hFFFF_FFFD);
        n_checks++;
        if (result !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mul_7x_m3_const got=%h exp=ffffffeb", result);
        end
        check_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000);
        n_checks++;
        if (result !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL mulh_min_const got=%h exp=40000000", result);
        end
        check_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (result !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mulhu_max_const got=%h exp=fffffffe", result);
        end
        check_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mulhsu_m1_const got=%h exp=ffffffff", result);
        end
    endtask

    task automatic test_div_directed;
`ifdef RV32M_DIV_EN
        check_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (result !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_m7_2_const got=%h exp=fffffffd", result);
        end
        check_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_m7_2_const got=%h exp=ffffffff", result);
        end
        check_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        check_op("remu_100_7", 3'b111, 32'd100, 32'd7);
        check_op("divu_by0", 3'b101, 32'd5, 32'd0);
        check_op("rem_by0", 3'b110, 32'd5, 32'd0);
        check_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
`else
        check_op("div_disabled", 3'b100, 32'd10, 32'd2);
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL div_disabled_const got=%h exp=00000000", result);
        end
`endif
    endtask

    task automatic test_flush;
        logic [31:0] prev;
        bit          seen = 1'b0;
        check_op("flush_pre", 3'b000, 32'd11, 32'd13);
        prev = result;
        @(posedge clk);
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd1000; rs2_val = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle busy=%b done=%b exp=0/0", busy, done);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_done got=1 exp=0");
        end
        n_checks++;
        if (result !== prev) begin
            n_fail++;
            $display("FAIL flush_result_held got=%h exp=%h", result, prev);
        end
        check_op("flush_post_3x4", 3'b000, 32'd3, 32'd4);
    endtask

    task automatic test_rst_mid;
        bit seen = 1'b0;
        check_op("rst_pre", 3'b000, 32'd5, 32'd9);
        @(posedge clk);
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd77; rs2_val = 32'd88; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (result !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state result=%h busy=%b done=%b exp=0/0/0", result, busy, done);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_mid_no_done got=1 exp=0");
        end
    endtask

    task automatic test_start_in_done;
        logic [31:0] res;
        int          lat;
        bit          ball;
        bit          seen = 1'b0;
        do_op(3'b000, 32'd6, 32'd7, res, lat, ball);
        n_checks++;
        if (res !== 32'd42 || lat != 33) begin
            n_fail++;
            $display("FAIL sid_first got=%h/%0d exp=0000002a/33", res, lat);
        end
        // Still in the done cycle: this request must be dropped.
        funct3 = 3'b000; rs1_val = 32'd100; rs2_val = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sid_busy got=%b exp=0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen || result !== 32'd42) begin
            n_fail++;
            $display("FAIL sid_ignored done_seen=%b result=%h exp=0/0000002a", seen, result);
        end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3:       a = $urandom_range(0, 100);
                default: ;
            endcase
            check_op("random", f3, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_flush();
        test_rst_mid();
        test_start_in_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32m_muldiv.md
RV32M_MULDIV -- requirements
Module: rv32m_muldiv

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (only 32 supported).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request strobe, sampled only when idle.
REQ-005 SHALL have port: funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: rs1_val  input  32  operand A (dividend / multiplicand).
REQ-007 SHALL have port: rs2_val  input  32  operand B (divisor / multiplier).
REQ-008 SHALL have port: flush  input  1  cancels the in-flight op.
REQ-009 SHALL have port: busy  output  1  high while an op is in flight (states MUL, DIV, DONE).
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: result  output  32  registered result, feeds mulmux input mul_out.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; done=1 only in DONE.
REQ-013 SHALL, in IDLE with start=1, latch funct3/operands; funct3[2]=0 -> MUL, funct3[2]=1 -> DIV (or DONE per fast paths).
REQ-014 SHALL ignore start outside IDLE; operands latched at acceptance, later input changes have no effect.
REQ-015 SHALL run MUL as 32 iterations of 1-bit shift-add on magnitudes (sign handling per funct3), 64-bit product, sign fixed up in DONE entry.
REQ-016 SHALL return product[31:0] for MUL, product[63:32] for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-017 SHALL run DIV as 32 iterations of restoring division on magnitudes; quotient sign = sign(A) XOR sign(B), remainder sign = sign(A) (signed ops only).
REQ-018 SHALL make iterative latency fixed: start accepted in cycle N, done=1 in cycle N+33, 32-iteration counter wrapping 31->0 triggers MUL/DIV -> DONE.
REQ-019 SHALL fast-path divide-by-zero (B=0): DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> A; IDLE -> DONE directly, done in cycle N+1.
REQ-020 SHALL fast-path signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0; done in cycle N+1.
REQ-021 SHALL leave DONE -> IDLE unconditionally after one cycle; start during DONE is ignored.
REQ-022 SHALL hold result stable from done until the next done; result not updated during iterations.
REQ-023 SHALL, on flush=1 in any state, go to IDLE next cycle with no done pulse; result unchanged; flush and start together in IDLE -> start ignored.
REQ-024 SHALL give rst priority over flush and start.

Reset
REQ-025 SHALL on rst=1 at a clk edge set state=IDLE, busy=0, done=0, result=0x00000000, counter=0.
REQ-026 SHALL, on rst mid-operation, abandon the op with no done pulse.

Configuration
REQ-027 SHALL use macro RV32M_DIV_EN; defined: divider, DIV state and REQ-017/019/020 included.
REQ-028 SHALL, without RV32M_DIV_EN, omit DIV state and divider datapath; funct3[2]=1 ops go IDLE -> DONE with result 0x00000000, done in cycle N+1; MUL ops unchanged.

Verification
REQ-029 SHALL test MUL A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, busy high throughout.
REQ-030 SHALL test high products: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL test signed divide: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; latency 33.
REQ-032 SHALL test fast paths: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each done 1 cycle after start.
REQ-033 SHALL test flush: MUL started, flush at iteration 10 -> no done, busy=0 next cycle, previous result held; next MUL 3*4 -> 12 with normal latency.
REQ-034 SHALL test rst asserted at iteration 5 -> result 0, done never pulses; start in DONE cycle ignored; without RV32M_DIV_EN, DIV 10/2 -> 0 in 1 cycle.
